// File: rtl/alu_param.sv
// Multi-cycle signed ALU: single-cycle add/sub/logic/slt, shift-add multiply, restoring divide.
// The divider is only built when ALU_PARAM_DIV_EN is defined; otherwise opcode 011 completes at once with zeros.
module alu_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [1:0]       fsm_state
);

    // Handshake: an op is accepted on a rising edge with start=1 and busy=0; start is
    // ignored while busy=1; done pulses for one cycle when result/flags are updated.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_PARAM_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic [WIDTH-1:0]   mag_a, mag_b, sum, diff;
    logic               slt;
    logic               q_single, q_ovf, q_dbz;
    logic [WIDTH-1:0]   q_result, q_rem;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    assign fsm_state = state;
    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign sum   = a + b;
    assign diff  = a - b;
    assign slt   = $signed(a) < $signed(b);

    // Final multiply iteration feeds the result directly, so use the next accumulator value.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_res  = neg ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
    assign mul_ovf  = neg ? (acc_next > NEG_MAX) : (acc_next > POS_MAX);

`ifdef ALU_PARAM_DIV_EN
    logic [WIDTH-1:0] quo, rem_r, dvsr;
    logic             sign_a;
    logic [WIDTH:0]   r_shift;
    logic             fits;
    logic [WIDTH-1:0] r_next, q_next, div_res, div_rem;
    logic             div_ovf;

    assign r_shift = {rem_r, quo[WIDTH-1]};
    assign fits    = r_shift >= {1'b0, dvsr};
    // When the trial subtraction succeeds the difference is below dvsr, so WIDTH bits suffice.
    assign r_next  = fits ? (r_shift[WIDTH-1:0] - dvsr) : r_shift[WIDTH-1:0];
    assign q_next  = {quo[WIDTH-2:0], fits};
    assign div_res = neg ? (~q_next + 1'b1) : q_next;
    assign div_rem = sign_a ? (~r_next + 1'b1) : r_next;
    assign div_ovf = !neg && q_next[WIDTH-1];
`endif

    always_comb begin
        q_single = 1'b1;
        q_result = '0;
        q_rem    = '0;
        q_ovf    = 1'b0;
        q_dbz    = 1'b0;
        case (opcode)
            3'b000: begin
                q_result = sum;
                q_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                q_result = diff;
                q_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: q_single = 1'b0;
            3'b011: begin
`ifdef ALU_PARAM_DIV_EN
                if (b == '0) begin
                    q_result = '1;
                    q_rem    = a;
                    q_dbz    = 1'b1;
                end else begin
                    q_single = 1'b0;
                end
`endif
            end
            3'b100: q_result = a & b;
            3'b101: q_result = a | b;
            3'b110: q_result = a ^ b;
            default: q_result = {{(WIDTH-1){1'b0}}, slt};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            neg         <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            result      <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef ALU_PARAM_DIV_EN
            quo         <= '0;
            rem_r       <= '0;
            dvsr        <= '0;
            sign_a      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= '0;
                        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        if (q_single) begin
                            done        <= 1'b1;
                            result      <= q_result;
                            remainder   <= q_rem;
                            overflow    <= q_ovf;
                            div_by_zero <= q_dbz;
                        end else if (opcode == 3'b010) begin
                            state  <= S_MUL;
                            busy   <= 1'b1;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, mag_a};
                            mplier <= mag_b;
                        end
`ifdef ALU_PARAM_DIV_EN
                        else begin
                            state  <= S_DIV;
                            busy   <= 1'b1;
                            quo    <= mag_a;
                            rem_r  <= '0;
                            dvsr   <= mag_b;
                            sign_a <= a[WIDTH-1];
                        end
`endif
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        count       <= '0;
                        result      <= mul_res;
                        remainder   <= '0;
                        overflow    <= mul_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
`ifdef ALU_PARAM_DIV_EN
                S_DIV: begin
                    quo   <= q_next;
                    rem_r <= r_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        count       <= '0;
                        result      <= div_res;
                        remainder   <= div_rem;
                        overflow    <= div_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param (WIDTH=16); divide expectations follow ALU_PARAM_DIV_EN.
module tb_alu_param;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   opcode;
    logic [W-1:0] a, b;
    logic [W-1:0] result, remainder;
    logic         busy, done, overflow, div_by_zero;
    logic [1:0]   fsm_state;

    alu_param #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
        .result(result), .remainder(remainder), .busy(busy), .done(done),
        .overflow(overflow), .div_by_zero(div_by_zero), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;
    logic [2*W+1:0] exp_q[$];
    int             cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response and arrive on time.
    always @(negedge clk) begin : monitor
        logic [2*W+1:0] e;
        int             c;
        if (reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done with empty queue at cycle %0d", cycle);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("done_data", {result, remainder, overflow, div_by_zero}, e);
                check("done_latency", cycle, c);
            end
        end
    end

    // Drives one request at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input int lat, input logic [W-1:0] r, input logic [W-1:0] rm,
                         input logic ov, input logic dz, input bit expect_done);
        opcode = op;
        a      = aa;
        b      = bb;
        start  = 1'b1;
        if (expect_done) begin
            exp_q.push_back({r, rm, ov, dz});
            cyc_q.push_back(cycle + lat);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (expect_done && lat == 1) check("busy_low", busy, 1'b0);
    endtask

    // Multi-cycle op: counts busy cycles, pokes start and scrambles inputs while busy.
    task automatic run_long(input logic [2:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic [W-1:0] r, input logic [W-1:0] rm, input logic ov);
        int n;
        issue(op, aa, bb, W + 1, r, rm, ov, 1'b0, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            start  = (n == 3 || n == 9);
            opcode = 3'b000;
            a      = W'($urandom_range(0, 65535));
            b      = W'($urandom_range(0, 65535));
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", n, W);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 3'b000;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_state", fsm_state, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle ops, issued back to back
        issue(3'b000, 16'd30000, 16'd10000, 1, 16'h9C40, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(3'b001, 16'd100,   16'hFFCE,  1, 16'h0096, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(3'b001, 16'h8000,  16'h0001,  1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(3'b100, 16'hF0F0,  16'h0FF0,  1, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(3'b101, 16'hF0F0,  16'h0FF0,  1, 16'hFFF0, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(3'b110, 16'hF0F0,  16'h0FF0,  1, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(3'b111, 16'hFFFB,  16'h0003,  1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(3'b111, 16'h0003,  16'hFFFB,  1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Multiply; each new op starts on the negedge right after the previous done
        run_long(3'b010, 16'hFFF9, 16'd9,   16'hFFC1, 16'h0000, 1'b0);
        run_long(3'b010, 16'd300,  16'd300, 16'h5F90, 16'h0000, 1'b1);
        run_long(3'b010, 16'hFF80, 16'd256, 16'h8000, 16'h0000, 1'b0);
        run_long(3'b010, 16'd256,  16'd128, 16'h8000, 16'h0000, 1'b1);

`ifdef ALU_PARAM_DIV_EN
        run_long(3'b011, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0);
        run_long(3'b011, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1);
        run_long(3'b011, 16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);
        issue(3'b011, 16'd5, 16'd0, 1, 16'hFFFF, 16'h0005, 1'b0, 1'b1, 1'b1);
`else
        issue(3'b011, 16'd20, 16'd4, 1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
`endif

        // Put a nonzero result in place, then abort a multiply with reset
        issue(3'b101, 16'h1234, 16'h0001, 1, 16'h1235, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(3'b010, 16'd1234, 16'd5, W + 1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_before_abort", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flags", {overflow, div_by_zero}, 0);
        check("abort_state", fsm_state, 0);
        issue(3'b001, 16'd3, 16'd5, 1, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
        end
        repeat (30) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port opcode  input  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 set-less-than (signed).
REQ-006 SHALL have ports a, b  input  WIDTH  signed two's-complement operands.
REQ-007 SHALL have port result  output  WIDTH  registered result, or quotient for div.
REQ-008 SHALL have port remainder  output  WIDTH  registered div remainder; 0 for all other ops.
REQ-009 SHALL have port busy  output  1  high while a multi-cycle op is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports overflow, div_by_zero  output  1 each  status flags, valid with done and held until next completion.

Function
REQ-012 SHALL capture opcode, a and b on the rising edge where start=1 and busy=0 (the sampling edge); later input changes SHALL NOT affect the op in flight.
REQ-013 SHALL ignore start while busy=1; no queueing.
REQ-014 SHALL use FSM states IDLE, MUL, DIV; IDLE->MUL on accepted mul; IDLE->DIV on accepted div with b!=0; MUL/DIV->IDLE after WIDTH iteration cycles; all other accepted ops stay in IDLE.
REQ-015 SHALL have latency L, counted in rising edges with the sampling edge as edge 1: L=1 for add/sub/logic/slt and for div by zero; L=WIDTH+1 for mul and div.
REQ-016 SHALL raise done and update result/flags after edge L, and hold done for exactly one cycle; busy SHALL be 1 after edges 1..WIDTH of mul/div and 0 otherwise.
REQ-017 SHALL keep result, remainder and flags stable between completions.
REQ-018 SHALL compute add/sub modulo 2^WIDTH, with overflow=1 on signed overflow.
REQ-019 SHALL compute mul as a radix-2 shift-add over operand magnitudes, one iteration per cycle, with the sign applied at the end; result is the low WIDTH bits; overflow=1 if the true product is outside the signed WIDTH range.
REQ-020 SHALL compute div by a restoring algorithm, one quotient bit per cycle, on magnitudes; quotient truncates toward zero; remainder takes the sign of a.
REQ-021 SHALL, for div with b=0, output result = all ones, remainder = a, div_by_zero=1, overflow=0.
REQ-022 SHALL, for div with a = most negative and b = -1, output result = most negative, remainder 0, overflow=1.
REQ-023 SHALL set overflow=0 and div_by_zero=0 for and/or/xor/slt; slt result is 1 if a<b signed, else 0.
REQ-024 SHALL allow a new start on the edge immediately after done is raised.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, force state IDLE, result=0, remainder=0, busy=0, done=0, overflow=0, div_by_zero=0, and clear the iteration counter and datapath registers.
REQ-026 SHALL abort any in-flight op on reset without producing done; reset SHALL have priority over start on the same edge.

Configuration
REQ-027 SHALL compile the divider when macro ALU_PARAM_DIV_EN is defined, behaving per REQ-020..022.
REQ-028 SHALL, without ALU_PARAM_DIV_EN, contain no divider logic and treat opcode 011 as L=1 with result=0, remainder=0, overflow=0 and div_by_zero=0.

Verification (WIDTH=16, ALU_PARAM_DIV_EN defined unless stated)
REQ-029 SHALL cover add a=30000, b=10000 -> result 0x9C40, overflow=1, done after edge 1, busy never high.
REQ-030 SHALL cover mul a=-7, b=9 -> result 0xFFC1, overflow=0, busy high for 16 cycles, done after edge 17; start pulses during busy are ignored.
REQ-031 SHALL cover div a=-100, b=7 -> result 0xFFF2, remainder 0xFFFE, done after edge 17; and div a=0x8000, b=0xFFFF -> result 0x8000, overflow=1.
REQ-032 SHALL cover div a=5, b=0 -> result 0xFFFF, remainder 0x0005, div_by_zero=1, done after edge 1.
REQ-033 SHALL cover reset asserted 5 cycles into a mul -> no done, all outputs 0 next cycle; a sub a=3, b=5 started right after -> result 0xFFFE, done after edge 1.
REQ-034 SHALL cover a build without ALU_PARAM_DIV_EN: opcode 011 with a=20, b=4 -> result 0, remainder 0, flags 0, done after edge 1.
